// File: rtl/apb_upsizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_upsizer_pkg
//  Description : Shared constants, typedefs and FSM encoding for the
//                narrow-to-wide APB upsizer. The constants describe the
//                default build (13-bit byte address, 16-bit narrow data,
//                64-bit wide data); the RTL modules recompute their own
//                widths from their parameters and only use these as defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_upsizer_pkg;

    localparam int c_ADDR_WIDTH  = 13;
    localparam int c_DATAN_WIDTH = 16;
    localparam int c_DATAW_WIDTH = 64;

    // Bytes per wide word and per narrow word.
    localparam int c_NBW = c_DATAW_WIDTH / 8;
    localparam int c_NBN = c_DATAN_WIDTH / 8;

    // Width of a byte-offset-within-wide-word field. A one-byte wide bus
    // still gets a 1-bit field so no zero-width vectors appear.
    function automatic int off_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

    localparam int c_OFF_WIDTH = off_width(c_NBW);

    typedef logic [c_ADDR_WIDTH-1:0]  addrw_t;
    typedef logic [c_DATAW_WIDTH-1:0] dataw_t;
    typedef logic [c_DATAN_WIDTH-1:0] datan_t;
    typedef logic [c_OFF_WIDTH-1:0]   off_t;

    // IDLE -> SETUP -> ACCESS -> (SETUP for the next piece | RESP) -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_lane_merge
//  Description : Combinational big-endian byte-lane mapper between one wide
//                word and a narrow access that starts at byte offset 'off'.
//                Narrow byte j belongs to wide byte off+j; when that index
//                runs past the end of the word the byte belongs to the next
//                word (piece_sel=1) at index off+j-NBW.
//  Ports       : dataw     - wide word read from the completer
//                off       - byte offset of the narrow address in its word
//                datan     - narrow write data
//                piece_sel - 0: first wide word, 1: following wide word
//                merged    - dataw with the covered bytes replaced by datan
//                extracted - narrow bytes supplied by this word, other
//                            narrow bytes zero (pieces are OR-combined)
//  Revision    : 1.0  initial release
// ============================================================================
module apb_lane_merge
    import apb_upsizer_pkg::*;
#(
    parameter int DATAW_WIDTH = c_DATAW_WIDTH,
    parameter int DATAN_WIDTH = c_DATAN_WIDTH
) (
    input  logic [DATAW_WIDTH-1:0]                  dataw,
    input  logic [off_width(DATAW_WIDTH/8)-1:0]     off,
    input  logic [DATAN_WIDTH-1:0]                  datan,
    input  logic                                    piece_sel,
    output logic [DATAW_WIDTH-1:0]                  merged,
    output logic [DATAN_WIDTH-1:0]                  extracted
);

    localparam int c_WB = DATAW_WIDTH / 8;
    localparam int c_NB = DATAN_WIDTH / 8;

    always_comb begin
        merged    = dataw;
        extracted = '0;
        for (int k = 0; k < c_WB; k++) begin
            for (int j = 0; j < c_NB; j++) begin
                // Wide byte k of the selected piece lines up with narrow
                // byte j when off+j equals k (first word) or k+NBW (second).
                if ((int'(off) + j) == (piece_sel ? (k + c_WB) : k)) begin
                    merged[DATAW_WIDTH-1-8*k -: 8]    = datan[DATAN_WIDTH-1-8*j -: 8];
                    extracted[DATAN_WIDTH-1-8*j -: 8] = dataw[DATAW_WIDTH-1-8*k -: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_upsizer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_upsizer
//  Description : Narrow APB requester to wide APB completer bridge. Byte
//                addresses may be unaligned, so one narrow access maps to one
//                or two wide words. Reads issue one wide read per word; writes
//                issue a read-modify-write per word because the wide bus has
//                no byte strobes. Both sides are big-endian. Every output is
//                driven from a flop.
//  Ports       : PCLK, PRESET             - clock, synchronous active-high reset
//                s_P*                     - narrow APB completer interface
//                m_P*                     - wide APB requester interface
//  Revision    : 1.0  initial release
// ============================================================================
module apb_upsizer
    import apb_upsizer_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int DATAN_WIDTH = c_DATAN_WIDTH,
    parameter int DATAW_WIDTH = c_DATAW_WIDTH
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    // narrow side
    input  logic [ADDR_WIDTH-1:0]   s_PADDR,
    input  logic                    s_PSEL,
    input  logic                    s_PENABLE,
    input  logic                    s_PWRITE,
    input  logic [DATAN_WIDTH-1:0]  s_PWDATA,
    output logic [DATAN_WIDTH-1:0]  s_PRDATA,
    output logic                    s_PREADY,
    output logic                    s_PSLVERR,
    // wide side
    output logic [ADDR_WIDTH-1:0]   m_PADDR,
    output logic                    m_PSEL,
    output logic                    m_PENABLE,
    output logic                    m_PWRITE,
    output logic [DATAW_WIDTH-1:0]  m_PWDATA,
    input  logic [DATAW_WIDTH-1:0]  m_PRDATA,
    input  logic                    m_PREADY,
    input  logic                    m_PSLVERR
);

    localparam int c_WB   = DATAW_WIDTH / 8;
    localparam int c_NB   = DATAN_WIDTH / 8;
    localparam int c_OFFW = off_width(c_WB);

    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'(c_WB - 1);
    localparam logic [ADDR_WIDTH-1:0] c_WB_ADDR  = ADDR_WIDTH'(c_WB);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATAN_WIDTH-1:0]  r_wdata;
    logic                    r_span;
    logic                    r_piece;
    logic [DATAN_WIDTH-1:0]  r_acc;

    logic [DATAN_WIDTH-1:0]  r_s_prdata;
    logic                    r_s_pready;
    logic                    r_s_pslverr;
    logic [ADDR_WIDTH-1:0]   r_m_paddr;
    logic                    r_m_psel;
    logic                    r_m_penable;
    logic                    r_m_pwrite;
    logic [DATAW_WIDTH-1:0]  r_m_pwdata;

    // Next-state values
    state_t                  w_state;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_write;
    logic [DATAN_WIDTH-1:0]  w_wdata;
    logic                    w_span;
    logic                    w_piece;
    logic [DATAN_WIDTH-1:0]  w_acc;

    logic [DATAN_WIDTH-1:0]  w_s_prdata;
    logic                    w_s_pready;
    logic                    w_s_pslverr;
    logic [ADDR_WIDTH-1:0]   w_m_paddr;
    logic                    w_m_psel;
    logic                    w_m_penable;
    logic                    w_m_pwrite;
    logic [DATAW_WIDTH-1:0]  w_m_pwdata;

    // ------------------------------------------------------------------
    // Address decomposition
    // ------------------------------------------------------------------
    logic [c_OFFW-1:0]       w_s_off;
    logic                    w_s_span;
    logic [ADDR_WIDTH-1:0]   w_s_w0;
    logic [c_OFFW-1:0]       w_r_off;
    logic [ADDR_WIDTH-1:0]   w_r_w1;

    assign w_s_off  = c_OFFW'(s_PADDR & c_OFF_MASK);
    assign w_s_span = (int'(w_s_off) + c_NB) > c_WB;
    assign w_s_w0   = s_PADDR & ~c_OFF_MASK;
    assign w_r_off  = c_OFFW'(r_addr & c_OFF_MASK);
    // Natural truncation gives the modulo-2^ADDR_WIDTH wrap of the second word.
    assign w_r_w1   = (r_addr & ~c_OFF_MASK) + c_WB_ADDR;

    // ------------------------------------------------------------------
    // Byte-lane mapping for the piece currently on the wide bus
    // ------------------------------------------------------------------
    logic [DATAW_WIDTH-1:0]  w_merged;
    logic [DATAN_WIDTH-1:0]  w_extracted;

    apb_lane_merge #(
        .DATAW_WIDTH (DATAW_WIDTH),
        .DATAN_WIDTH (DATAN_WIDTH)
    ) u_lane_merge (
        .dataw     (m_PRDATA),
        .off       (w_r_off),
        .datan     (r_wdata),
        .piece_sel (r_piece),
        .merged    (w_merged),
        .extracted (w_extracted)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_write     = r_write;
        w_wdata     = r_wdata;
        w_span      = r_span;
        w_piece     = r_piece;
        w_acc       = r_acc;
        w_s_prdata  = r_s_prdata;
        w_s_pready  = 1'b0;
        w_s_pslverr = 1'b0;
        w_m_paddr   = r_m_paddr;
        w_m_psel    = r_m_psel;
        w_m_penable = r_m_penable;
        w_m_pwrite  = r_m_pwrite;
        w_m_pwdata  = r_m_pwdata;

        case (r_state)
            ST_IDLE: begin
                if (s_PSEL && s_PENABLE) begin
                    w_addr      = s_PADDR;
                    w_write     = s_PWRITE;
                    w_wdata     = s_PWDATA;
                    w_span      = w_s_span;
                    w_piece     = 1'b0;
                    w_acc       = '0;
                    // Both reads and writes begin with a read of the first word.
                    w_m_paddr   = w_s_w0;
                    w_m_psel    = 1'b1;
                    w_m_penable = 1'b0;
                    w_m_pwrite  = 1'b0;
                    w_state     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_m_penable = 1'b1;
                w_state     = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (m_PREADY) begin
                    w_m_penable = 1'b0;
                    if (m_PSLVERR) begin
                        // Abort every remaining piece, including the write
                        // half of a read-modify-write whose read failed.
                        w_m_psel    = 1'b0;
                        w_m_pwrite  = 1'b0;
                        w_s_pready  = 1'b1;
                        w_s_pslverr = 1'b1;
                        w_s_prdata  = '0;
                        w_state     = ST_RESP;
                    end else if (r_write && !r_m_pwrite) begin
                        // Read half of a RMW done: write back the same word.
                        w_m_pwrite = 1'b1;
                        w_m_pwdata = w_merged;
                        w_state    = ST_SETUP;
                    end else begin
                        if (!r_write) begin
                            w_acc = r_acc | w_extracted;
                        end
                        if (r_span && !r_piece) begin
                            w_piece    = 1'b1;
                            w_m_paddr  = w_r_w1;
                            w_m_pwrite = 1'b0;
                            w_state    = ST_SETUP;
                        end else begin
                            w_m_psel   = 1'b0;
                            w_m_pwrite = 1'b0;
                            w_s_pready = 1'b1;
                            w_s_prdata = r_write ? '0 : (r_acc | w_extracted);
                            w_state    = ST_RESP;
                        end
                    end
                end
            end

            ST_RESP: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_span      <= 1'b0;
            r_piece     <= 1'b0;
            r_acc       <= '0;
            r_s_prdata  <= '0;
            r_s_pready  <= 1'b0;
            r_s_pslverr <= 1'b0;
            r_m_paddr   <= '0;
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_m_pwrite  <= 1'b0;
            r_m_pwdata  <= '0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_write     <= w_write;
            r_wdata     <= w_wdata;
            r_span      <= w_span;
            r_piece     <= w_piece;
            r_acc       <= w_acc;
            r_s_prdata  <= w_s_prdata;
            r_s_pready  <= w_s_pready;
            r_s_pslverr <= w_s_pslverr;
            r_m_paddr   <= w_m_paddr;
            r_m_psel    <= w_m_psel;
            r_m_penable <= w_m_penable;
            r_m_pwrite  <= w_m_pwrite;
            r_m_pwdata  <= w_m_pwdata;
        end
    end

    assign s_PRDATA  = r_s_prdata;
    assign s_PREADY  = r_s_pready;
    assign s_PSLVERR = r_s_pslverr;
    assign m_PADDR   = r_m_paddr;
    assign m_PSEL    = r_m_psel;
    assign m_PENABLE = r_m_penable;
    assign m_PWRITE  = r_m_pwrite;
    assign m_PWDATA  = r_m_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_upsizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_upsizer
//  Description : Directed bench for apb_upsizer with a wide memory model.
//                Table of narrow transfers with hand-computed results, then
//                hand-written error, wait-state and mid-transfer reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_upsizer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [12:0] s_PADDR;
    logic        s_PSEL, s_PENABLE, s_PWRITE;
    logic [15:0] s_PWDATA;
    logic [15:0] s_PRDATA;
    logic        s_PREADY, s_PSLVERR;
    logic [12:0] m_PADDR;
    logic        m_PSEL, m_PENABLE, m_PWRITE;
    logic [63:0] m_PWDATA;
    logic [63:0] m_PRDATA;
    logic        m_PREADY, m_PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_upsizer dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .s_PADDR   (s_PADDR),
        .s_PSEL    (s_PSEL),
        .s_PENABLE (s_PENABLE),
        .s_PWRITE  (s_PWRITE),
        .s_PWDATA  (s_PWDATA),
        .s_PRDATA  (s_PRDATA),
        .s_PREADY  (s_PREADY),
        .s_PSLVERR (s_PSLVERR),
        .m_PADDR   (m_PADDR),
        .m_PSEL    (m_PSEL),
        .m_PENABLE (m_PENABLE),
        .m_PWRITE  (m_PWRITE),
        .m_PWDATA  (m_PWDATA),
        .m_PRDATA  (m_PRDATA),
        .m_PREADY  (m_PREADY),
        .m_PSLVERR (m_PSLVERR)
    );

    // ---------------- wide completer / memory model ----------------
    logic [63:0] mem [0:1023];
    bit          loaded = 1'b0;
    int          cfg_wait = 0;
    bit          err_arm = 1'b0;
    int          wcnt = 0;
    int          n_wide = 0, n_wr = 0, n_wr0 = 0, n_misalign = 0, n_unstable = 0;
    logic [12:0] last_waddr = '0;
    logic [63:0] last_wdata = '0;
    logic [77:0] hold = '0;
    bit          hold_v = 1'b0;

    assign m_PREADY  = m_PSEL && m_PENABLE && (wcnt >= cfg_wait);
    assign m_PSLVERR = m_PREADY && err_arm;
    assign m_PRDATA  = mem[m_PADDR[12:3]];

    always @(posedge PCLK) begin
        if (m_PSEL && m_PENABLE && !m_PREADY) wcnt <= wcnt + 1;
        else                                  wcnt <= 0;
    end

    always @(posedge PCLK) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
            mem[13'h0010 >> 3] = 64'h0011223344556677;
            mem[13'h0018 >> 3] = 64'h8899AABBCCDDEEFF;
            loaded = 1'b1;
        end
        if (m_PSEL && m_PENABLE && hold_v && ({m_PADDR, m_PWRITE, m_PWDATA} !== hold))
            n_unstable++;
        if (m_PSEL && (m_PADDR[2:0] != 3'd0)) n_misalign++;
        if (m_PSEL && m_PENABLE && m_PREADY) begin
            n_wide++;
            if (m_PWRITE && !m_PSLVERR) begin
                mem[m_PADDR[12:3]] = m_PWDATA;
                n_wr++;
                last_waddr = m_PADDR;
                last_wdata = m_PWDATA;
                if (m_PADDR == 13'h0000) n_wr0++;
            end
        end
        hold_v = m_PSEL && !(m_PENABLE && m_PREADY) && !PRESET;
        hold   = {m_PADDR, m_PWRITE, m_PWDATA};
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input bit wr, input logic [12:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic err, output int lat);
        s_PSEL    = 1'b1;
        s_PENABLE = 1'b0;
        s_PWRITE  = wr;
        s_PADDR   = a;
        s_PWDATA  = d;
        @(posedge PCLK); #1;
        s_PENABLE = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge PCLK); #1;
            lat++;
            if (s_PREADY || lat >= 60) break;
        end
        rd        = s_PRDATA;
        err       = s_PSLVERR;
        s_PSEL    = 1'b0;
        s_PENABLE = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_nwide;
        int          exp_nwr;
        logic [12:0] exp_waddr;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        err;
        int          lat, nw0, nwr0, nz0, cnt;

        vecs[0]  = '{1'b0, 13'h0010, 16'h0000, 16'h0011, 3, 1, 0, 13'h0, 64'h0};
        vecs[1]  = '{1'b0, 13'h0017, 16'h0000, 16'h7788, 5, 2, 0, 13'h0, 64'h0};
        vecs[2]  = '{1'b1, 13'h0013, 16'hBEEF, 16'h0000, 5, 2, 1, 13'h0010, 64'h001122BEEF556677};
        vecs[3]  = '{1'b0, 13'h0013, 16'h0000, 16'hBEEF, 3, 1, 0, 13'h0, 64'h0};
        vecs[4]  = '{1'b0, 13'h0012, 16'h0000, 16'h22BE, 3, 1, 0, 13'h0, 64'h0};
        vecs[5]  = '{1'b0, 13'h001E, 16'h0000, 16'hEEFF, 3, 1, 0, 13'h0, 64'h0};
        vecs[6]  = '{1'b1, 13'h1FFF, 16'hA55A, 16'h0000, 9, 4, 2, 13'h0000, 64'h5A00000000000000};
        vecs[7]  = '{1'b0, 13'h1FFF, 16'h0000, 16'hA55A, 5, 2, 0, 13'h0, 64'h0};
        vecs[8]  = '{1'b1, 13'h0016, 16'h1234, 16'h0000, 5, 2, 1, 13'h0010, 64'h001122BEEF551234};
        vecs[9]  = '{1'b0, 13'h0017, 16'h0000, 16'h3488, 5, 2, 0, 13'h0, 64'h0};
        vecs[10] = '{1'b1, 13'h0017, 16'hC3D4, 16'h0000, 9, 4, 2, 13'h0018, 64'hD499AABBCCDDEEFF};
        vecs[11] = '{1'b0, 13'h0016, 16'h0000, 16'h12C3, 3, 1, 0, 13'h0, 64'h0};

        PRESET = 1'b1; s_PSEL = 1'b0; s_PENABLE = 1'b0; s_PWRITE = 1'b0;
        s_PADDR = '0; s_PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_s_PREADY",  64'(s_PREADY),  64'h0);
        chk("rst_s_PSLVERR", 64'(s_PSLVERR), 64'h0);
        chk("rst_s_PRDATA",  64'(s_PRDATA),  64'h0);
        chk("rst_m_PSEL",    64'(m_PSEL),    64'h0);
        chk("rst_m_PENABLE", 64'(m_PENABLE), 64'h0);
        chk("rst_m_PWRITE",  64'(m_PWRITE),  64'h0);
        chk("rst_m_PADDR",   64'(m_PADDR),   64'h0);
        chk("rst_m_PWDATA",  m_PWDATA,       64'h0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            nw0  = n_wide;
            nwr0 = n_wr;
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_slverr", i), 64'(err), 64'h0);
            chk($sformatf("v%0d_wide_xfers", i), 64'(n_wide - nw0), 64'(vecs[i].exp_nwide));
            chk($sformatf("v%0d_wide_writes", i), 64'(n_wr - nwr0), 64'(vecs[i].exp_nwr));
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_last_waddr", i), 64'(last_waddr), 64'(vecs[i].exp_waddr));
                chk($sformatf("v%0d_last_wdata", i), last_wdata, vecs[i].exp_wdata);
            end else begin
                chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            end
        end
        chk("mem_1FF8_after_wrap_write", mem[13'h1FF8 >> 3], 64'h00000000000000A5);
        chk("mem_0000_after_wrap_write", mem[0], 64'h5A00000000000000);

        // ---------------- RMW with read error and 3 wait states ----------------
        cfg_wait = 3; err_arm = 1'b1;
        nw0 = n_wide; nwr0 = n_wr;
        xfer(1'b1, 13'h0013, 16'h1234, rd, err, lat);
        err_arm = 1'b0; cfg_wait = 0;
        chk("rmw_err_slverr",  64'(err), 64'h1);
        chk("rmw_err_rdata",   64'(rd), 64'h0);
        chk("rmw_err_latency", 64'(lat), 64'd6);
        chk("rmw_err_wide_xfers", 64'(n_wide - nw0), 64'd1);
        chk("rmw_err_no_write", 64'(n_wr - nwr0), 64'd0);
        chk("rmw_err_mem_kept", mem[13'h0010 >> 3], 64'h001122BEEF5512C3);

        // ---------------- spanning read aborted by error on first piece ----------------
        err_arm = 1'b1;
        nw0 = n_wide;
        xfer(1'b0, 13'h0017, 16'h0000, rd, err, lat);
        err_arm = 1'b0;
        chk("rd_err_slverr",  64'(err), 64'h1);
        chk("rd_err_rdata",   64'(rd), 64'h0);
        chk("rd_err_latency", 64'(lat), 64'd3);
        chk("rd_err_wide_xfers", 64'(n_wide - nw0), 64'd1);

        // ---------------- spanning read with 2 wait states per piece ----------------
        cfg_wait = 2;
        xfer(1'b0, 13'h0017, 16'h0000, rd, err, lat);
        cfg_wait = 0;
        chk("rd_wait_rdata",   64'(rd), 64'hC3D4);
        chk("rd_wait_slverr",  64'(err), 64'h0);
        chk("rd_wait_latency", 64'(lat), 64'd9);

        // ---------------- reset during W(w0) of a wrapping write ----------------
        s_PSEL = 1'b1; s_PENABLE = 1'b0; s_PWRITE = 1'b1;
        s_PADDR = 13'h1FFF; s_PWDATA = 16'h1111;
        @(posedge PCLK); #1;
        s_PENABLE = 1'b1;
        cnt = 0;
        while (!(m_PSEL && m_PENABLE && m_PWRITE) && cnt < 30) begin
            @(posedge PCLK); #1;
            cnt++;
        end
        chk("rst_mid_reached_w0_access", 64'(cnt < 30), 64'h1);
        nz0 = n_wr0;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("rst_mid_m_PSEL",   64'(m_PSEL),   64'h0);
        chk("rst_mid_s_PREADY", 64'(s_PREADY), 64'h0);
        PRESET = 1'b0; s_PSEL = 1'b0; s_PENABLE = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge PCLK); #1;
            if (m_PSEL) cnt++;
        end
        chk("rst_mid_no_more_wide", 64'(cnt), 64'd0);
        chk("rst_mid_no_w1_write", 64'(n_wr0 - nz0), 64'd0);
        chk("rst_mid_mem_0000", mem[0], 64'h5A00000000000000);
        xfer(1'b0, 13'h0010, 16'h0000, rd, err, lat);
        chk("post_rst_rdata",   64'(rd), 64'h0011);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_slverr",  64'(err), 64'h0);

        // ---------------- whole-run wide bus properties ----------------
        chk("wide_addr_aligned", 64'(n_misalign), 64'd0);
        chk("wide_ctrl_stable",  64'(n_unstable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
